// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline constants and the IF-to-ID bus type
package cpu_pkg;

    localparam logic [31:0] RESET_PC        = 32'h1c00_0000;
    localparam int          FS_TO_DS_BUS_WD = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_bus_t;

endpackage

// File: rtl/if_inst_buf.sv
// rtl/if_inst_buf.sv - holds the fetched word while ID stalls, bypassing SRAM data otherwise
module if_inst_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] rdata,
    output logic [31:0] inst,
    output logic        valid
);

    logic [31:0] ibuf;
    logic        ibuf_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ibuf       <= 32'b0;
            ibuf_valid <= 1'b0;
        end else if (clear) begin
            ibuf_valid <= 1'b0;
        end else if (capture) begin
            ibuf       <= rdata;
            ibuf_valid <= 1'b1;
        end
    end

    assign inst  = ibuf_valid ? ibuf : rdata;
    assign valid = ibuf_valid;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, SRAM request, ID handoff and branch redirect
module if_stage
    import cpu_pkg::fs_to_ds_bus_t;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    logic          run_q;
    logic          fs_valid;
    logic [31:0]   fs_pc;
    logic [31:0]   nextpc;
    logic          fs_ready_go;
    logic          fs_allowin;
    logic          fetch_accept;
    logic          ibuf_capture;
    logic          ibuf_valid;
    logic [31:0]   held_inst;
    fs_to_ds_bus_t fs_to_ds_bus;

    assign fs_ready_go  = 1'b1;
    // A redirect always frees IF: the held instruction is wrong-path.
    assign fs_allowin   = !fs_valid || ds_allowin || br_taken;
    assign nextpc       = br_taken ? br_target : fs_pc + 32'd4;
    assign fetch_accept = run_q && fs_allowin;
    assign ibuf_capture = fs_valid && !ds_allowin && !ibuf_valid && !br_taken;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q    <= 1'b0;
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else begin
            run_q <= 1'b1;
            if (fetch_accept) begin
                fs_valid <= 1'b1;
                fs_pc    <= nextpc;
            end
        end
    end

    if_inst_buf u_inst_buf (
        .clk     (clk),
        .resetn  (resetn),
        .capture (ibuf_capture),
        .clear   (fetch_accept),
        .rdata   (inst_sram_rdata),
        .inst    (held_inst),
        .valid   (ibuf_valid)
    );

    assign fs_to_ds_bus    = '{pc: fs_pc, inst: held_inst};
    assign fs_to_ds_valid  = fs_valid && fs_ready_go && !br_taken;
    assign fs_to_ds_pc     = fs_to_ds_bus.pc;
    assign fs_to_ds_inst   = fs_to_ds_bus.inst;

    assign inst_sram_en    = fetch_accept;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage against a 1-cycle SRAM model
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_to_ds_valid;
    logic [31:0] fs_to_ds_pc;
    logic [31:0] fs_to_ds_inst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'b0;
    logic        garble = 1'b0;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_allowin      (ds_allowin),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_pc     (fs_to_ds_pc),
        .fs_to_ds_inst   (fs_to_ds_inst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h1c00_0008) ? 32'h0280_0421 : (a ^ 32'ha5a5_0000);
    endfunction

    // SRAM output is forced to garbage while disabled to prove the buffer holds the word.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= mem_word(inst_sram_addr);
        else if (garble)
            inst_sram_rdata <= 32'hdead_beef;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_monitor();
        logic [31:0] exp_pc;
        if (fs_to_ds_valid && ds_allowin) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_handoff", fs_to_ds_pc, 32'hffff_ffff);
            end else begin
                exp_pc = sb_q.pop_front();
                check_eq("sb_pc", fs_to_ds_pc, exp_pc);
                check_eq("sb_inst", fs_to_ds_inst, mem_word(exp_pc));
            end
        end
    endtask

    task automatic tick();
        #1;
        sb_monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_valid"}, fs_to_ds_valid, 1'b0);
        check_eq({pfx, "_en"}, inst_sram_en, 1'b0);
        check_eq({pfx, "_pc"}, fs_to_ds_pc, RST_PC - 32'd4);
        check_eq({pfx, "_addr"}, inst_sram_addr, RST_PC);
        check_eq({pfx, "_we"}, inst_sram_we, 4'b0);
        check_eq({pfx, "_wdata"}, inst_sram_wdata, 32'b0);
    endtask

    task automatic startup();
        resetn = 1'b1;
        #1;
        check_eq("pre_e1_en", inst_sram_en, 1'b0);
        @(posedge clk);
        #1;
        check_eq("e1_en", inst_sram_en, 1'b1);
        check_eq("e1_addr", inst_sram_addr, RST_PC);
        check_eq("e1_valid", fs_to_ds_valid, 1'b0);
        sb_q.push_back(RST_PC);
        @(posedge clk);
        #1;
        check_eq("e2_valid", fs_to_ds_valid, 1'b1);
        check_eq("e2_pc", fs_to_ds_pc, RST_PC);
        check_eq("e2_inst", fs_to_ds_inst, mem_word(RST_PC));
        check_eq("e2_addr", inst_sram_addr, RST_PC + 32'd4);
    endtask

    initial begin
        resetn     = 1'b0;
        ds_allowin = 1'b1;
        br_taken   = 1'b0;
        br_target  = 32'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        startup();

        sb_q.push_back(32'h1c00_0004);
        tick();
        sb_q.push_back(32'h1c00_0008);
        tick();
        check_eq("at8_pc", fs_to_ds_pc, 32'h1c00_0008);
        check_eq("at8_inst", fs_to_ds_inst, 32'h0280_0421);

        ds_allowin = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("stall_en", inst_sram_en, 1'b0);
            check_eq("stall_valid", fs_to_ds_valid, 1'b1);
            check_eq("stall_pc", fs_to_ds_pc, 32'h1c00_0008);
            check_eq("stall_inst", fs_to_ds_inst, 32'h0280_0421);
            if (k == 0) garble = 1'b1;
            tick();
        end
        ds_allowin = 1'b0;
        garble     = 1'b0;
        ds_allowin = 1'b1;
        #1;
        check_eq("release_en", inst_sram_en, 1'b1);
        check_eq("release_addr", inst_sram_addr, 32'h1c00_000c);
        tick();
        check_eq("at_c_pc", fs_to_ds_pc, 32'h1c00_000c);

        br_taken  = 1'b1;
        br_target = 32'h1c00_0100;
        #1;
        check_eq("br_valid", fs_to_ds_valid, 1'b0);
        check_eq("br_en", inst_sram_en, 1'b1);
        check_eq("br_addr", inst_sram_addr, 32'h1c00_0100);
        sb_q.push_back(32'h1c00_0100);
        tick();
        br_taken = 1'b0;
        #1;
        check_eq("post_br_valid", fs_to_ds_valid, 1'b1);
        check_eq("post_br_pc", fs_to_ds_pc, 32'h1c00_0100);

        for (int i = 0; i < 8; i++) begin
            check_eq("run_valid", fs_to_ds_valid, 1'b1);
            check_eq("run_addr", inst_sram_addr, 32'h1c00_0104 + 32'(4 * i));
            if (i < 7) sb_q.push_back(32'h1c00_0104 + 32'(4 * i));
            tick();
        end

        ds_allowin = 1'b0;
        tick();
        tick();
        check_eq("ibuf_hold_pc", fs_to_ds_pc, 32'h1c00_0120);
        br_taken  = 1'b1;
        br_target = 32'h1c00_0038;
        #1;
        check_eq("br_stall_valid", fs_to_ds_valid, 1'b0);
        check_eq("br_stall_en", inst_sram_en, 1'b1);
        check_eq("br_stall_addr", inst_sram_addr, 32'h1c00_0038);
        sb_q.push_back(32'h1c00_0038);
        tick();
        br_taken   = 1'b0;
        ds_allowin = 1'b1;
        #1;
        check_eq("br_stall_inst", fs_to_ds_inst, mem_word(32'h1c00_0038));
        sb_q.push_back(32'h1c00_003c);
        tick();
        tick();
        check_eq("at40_pc", fs_to_ds_pc, 32'h1c00_0040);

        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        startup();
        sb_q.push_back(32'h1c00_0004);
        tick();
        tick();

        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
